// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: request/response and data-memory bus of the load/store unit
interface dmem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_address, mem_data_in,
               mem_read_write, mem_access_size
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_address, mem_data_in,
               mem_read_write, mem_access_size
    );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: byte/half/word load-store unit over a 4-byte-write data memory; DMEM_RANGE_CHECK_EN adds an address range fault
module dmem_access_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h01000000,
    parameter int          DEPTH     = 1048576
) (
    input logic              clock,
    input logic              reset,
    dmem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(DEPTH) - 32'd4;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    state_t      state;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] wdata;
    logic        fault;
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] mask;
    logic [31:0] merged;
    assign fault = (bus.req_size == 2'b11)
                 | (bus.req_size == 2'b01 && bus.req_addr[0])
                 | (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                 | (RANGE_EN && (bus.req_addr < BASE_ADDR || bus.req_addr > LAST_ADDR));
    assign sh       = {lane, 3'b000};
    assign shifted  = bus.mem_data_out >> sh;
    assign load_ext = size == 2'b00 ? {{24{~uns & shifted[7]}}, shifted[7:0]}
                    : size == 2'b01 ? {{16{~uns & shifted[15]}}, shifted[15:0]}
                    : bus.mem_data_out;
    assign mask     = (size == 2'b00 ? 32'h000000FF : 32'h0000FFFF) << sh;
    assign merged   = (bus.mem_data_out & ~mask) | ((wdata << sh) & mask);
    // Request FSM; every bus and response output is a register updated here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            size                <= 2'b00;
            uns                 <= 1'b0;
            lane                <= 2'b00;
            wdata               <= 32'd0;
            bus.req_ready       <= 1'b1;
            bus.rsp_valid       <= 1'b0;
            bus.rsp_rdata       <= 32'd0;
            bus.rsp_error       <= 1'b0;
            bus.mem_address     <= BASE_ADDR;
            bus.mem_data_in     <= 32'd0;
            bus.mem_read_write  <= 1'b0;
            bus.mem_access_size <= 2'b00;
        end else begin
            bus.rsp_valid      <= 1'b0;
            bus.mem_read_write <= 1'b0;
            bus.req_ready      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        size                <= bus.req_size;
                        uns                 <= bus.req_unsigned;
                        lane                <= bus.req_addr[1:0];
                        wdata               <= bus.req_wdata;
                        bus.mem_access_size <= bus.req_size;
                        bus.rsp_rdata       <= 32'd0;
                        bus.rsp_error       <= fault;
                        if (fault) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                        end else begin
                            bus.mem_address <= {bus.req_addr[31:2], 2'b00};
                            if (!bus.req_write) begin
                                state <= LOAD;
                            end else if (bus.req_size == 2'b10) begin
                                state              <= WRITE;
                                bus.mem_read_write <= 1'b1;
                                bus.mem_data_in    <= bus.req_wdata;
                            end else begin
                                state <= RMW_RD;
                            end
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    bus.rsp_rdata <= load_ext;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RMW_RD: begin
                    bus.mem_data_in    <= merged;
                    bus.mem_read_write <= 1'b1;
                    state              <= WRITE;
                end
                WRITE: begin
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                default: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed checks of dmem_access_unit against a 16-word memory window
module tb_dmem_access_unit;
    localparam logic [31:0] BASE = 32'h01000000;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    logic [31:0] mem [16];
    logic        in_win;
    dmem_access_unit_if bus ();
    dmem_access_unit dut (.clock(clock), .reset(reset), .bus(bus.slave));
    always #5 clock = ~clock;
    assign in_win = (bus.mem_address - BASE) < 32'd64;
    assign bus.mem_data_out = in_win ? mem[bus.mem_address[5:2]] : 32'hDEADBEEF;
    // Memory model: full-word write on the clock edge while mem_read_write is high
    always @(posedge clock) begin
        if (bus.mem_read_write) begin
            wr_cnt <= wr_cnt + 1;
            if (in_win) mem[bus.mem_address[5:2]] <= bus.mem_data_in;
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic accept(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        int n = 0;
        @(negedge clock);
        while (!bus.req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_write = w;
        bus.req_size = sz;
        bus.req_unsigned = u;
        bus.req_addr = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
    endtask
    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_wr_at, input logic [31:0] exp_wd, input string tag);
        int lat = 0;
        int wr_at = 0;
        int wr0;
        logic [31:0] wd = 32'd0;
        accept(w, sz, u, a, d, tag);
        wr0 = wr_cnt;
        for (int k = 1; k <= 8; k++) begin
            if (bus.mem_read_write && wr_at == 0) begin
                wr_at = k;
                wd = bus.mem_data_in;
            end
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
            @(posedge clock);
            #1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(bus.rsp_error), 32'(exp_err));
        chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        chk({tag, "_wrs"}, 32'(wr_cnt - wr0), exp_wr_at != 0 ? 32'd1 : 32'd0);
        if (exp_wr_at != 0) begin
            chk({tag, "_wr_at"}, 32'(wr_at), 32'(exp_wr_at));
            chk({tag, "_wdata"}, wd, exp_wd);
        end
    endtask
    initial begin
        int wr0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.rsp_error), 32'd0);
        chk("rst_rw", 32'(bus.mem_read_write), 32'd0);
        chk("rst_addr", bus.mem_address, BASE);
        chk("rst_din", bus.mem_data_in, 32'd0);
        chk("rst_size", 32'(bus.mem_access_size), 32'd0);
        @(negedge clock) reset = 1'b0;
        xact(0, 2'b00, 0, 32'h01000011, 0, 2, 0, 32'hFFFFFFAA, 0, 0, "lb_s");
        xact(0, 2'b00, 1, 32'h01000011, 0, 2, 0, 32'h000000AA, 0, 0, "lb_u");
        xact(0, 2'b01, 0, 32'h01000012, 0, 2, 0, 32'hFFFF8899, 0, 0, "lh_s");
        xact(0, 2'b01, 1, 32'h01000010, 0, 2, 0, 32'h0000AABB, 0, 0, "lh_u");
        xact(0, 2'b01, 0, 32'h01000010, 0, 2, 0, 32'hFFFFAABB, 0, 0, "lh_s_lo");
        xact(0, 2'b10, 0, 32'h01000010, 0, 2, 0, 32'h8899AABB, 0, 0, "lw");
        xact(1, 2'b00, 0, 32'h01000013, 32'h0000005C, 3, 0, 32'd0, 2, 32'h5C99AABB, "sb");
        xact(0, 2'b10, 0, 32'h01000010, 0, 2, 0, 32'h5C99AABB, 0, 0, "lw_after_sb");
        xact(1, 2'b10, 0, 32'h01000012, 32'h11223344, 1, 1, 32'd0, 0, 0, "sw_misal");
        xact(0, 2'b11, 0, 32'h01000010, 0, 1, 1, 32'd0, 0, 0, "size11");
        xact(0, 2'b01, 0, 32'h01000011, 0, 1, 1, 32'd0, 0, 0, "lh_misal");
        xact(1, 2'b01, 0, 32'h01000010, 32'hFFFF1234, 3, 0, 32'd0, 2, 32'h5C991234, "sh");
        xact(1, 2'b10, 0, 32'h01000014, 32'hCAFEF00D, 2, 0, 32'd0, 1, 32'hCAFEF00D, "sw");
        xact(0, 2'b10, 0, 32'h01000014, 0, 2, 0, 32'hCAFEF00D, 0, 0, "lw_after_sw");
        accept(1, 2'b01, 0, 32'h01000012, 32'h0000ABCD, "rst_rmw");
        wr0 = wr_cnt;
        chk("rst_rmw_rw_before", 32'(bus.mem_read_write), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_rmw_ready_async", 32'(bus.req_ready), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_rmw_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rmw_rsp", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rmw_wrs", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_rmw_mem", mem[4], 32'h5C991234);
        accept(1, 2'b10, 0, 32'h01000014, 32'hFFFFFFFF, "rst_wr");
        wr0 = wr_cnt;
        chk("rst_wr_rw_before", 32'(bus.mem_read_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_wr_rw_async", 32'(bus.mem_read_write), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_wr_wrs", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_wr_mem", mem[5], 32'hCAFEF00D);
`ifdef DMEM_RANGE_CHECK_EN
        xact(0, 2'b10, 0, 32'h00FFFFFC, 0, 1, 1, 32'd0, 0, 0, "range");
`else
        xact(0, 2'b10, 0, 32'h00FFFFFC, 0, 2, 0, 32'hDEADBEEF, 0, 0, "range");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
